// File: rtl/sdpb_line_ctrl_if.sv
// Camera, RAM and drain-stream signals of the double-buffered line controller.
// slave = controller side, master = environment (camera, RAM, consumer).
interface sdpb_line_ctrl_if;
  logic        frame_start;
  logic        pix_valid;
  logic [15:0] pix_data;
  logic        line_end;

  logic        ram_cea;
  logic [10:0] ram_ada;
  logic [15:0] ram_din;
  logic        ram_ceb;
  logic [10:0] ram_adb;
  logic        ram_oce;
  logic [15:0] ram_dout;

  // Drain stream: a word moves on a cycle where out_valid and out_ready are both 1;
  // while out_valid=1 and out_ready=0, out_data/out_last hold their values.
  logic        out_valid;
  logic [15:0] out_data;
  logic        out_last;
  logic        out_ready;

  logic        line_avail;
  logic        overflow;
  logic [7:0]  drop_cnt;
  logic [3:0]  dbg_bank_st;

  modport slave (
    input  frame_start, pix_valid, pix_data, line_end, ram_dout, out_ready,
    output ram_cea, ram_ada, ram_din, ram_ceb, ram_adb, ram_oce,
           out_valid, out_data, out_last, line_avail, overflow, drop_cnt, dbg_bank_st
  );

  modport master (
    output frame_start, pix_valid, pix_data, line_end, ram_dout, out_ready,
    input  ram_cea, ram_ada, ram_din, ram_ceb, ram_adb, ram_oce,
           out_valid, out_data, out_last, line_avail, overflow, drop_cnt, dbg_bank_st
  );
endinterface

// File: rtl/sdpb_line_ctrl.sv
// Ping-pong line buffer: camera lines fill one 1024-word RAM bank while the other
// bank drains through a 2-cycle pipelined read port into a 3-entry output FIFO.
module sdpb_line_ctrl #(
  parameter int LINE_WORDS = 640
) (
  input  logic             clk,
  input  logic             reset_n,
  sdpb_line_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    B_EMPTY    = 2'd0,
    B_FILLING  = 2'd1,
    B_FULL     = 2'd2,
    B_DRAINING = 2'd3
  } bank_st_e;

  localparam logic [10:0] LW = 11'(LINE_WORDS);

  bank_st_e    st_q [2];
  bank_st_e    st_d [2];
  logic [10:0] len_q [2];
  logic [10:0] len_d [2];
  logic        w_q, w_d, r_q, r_d, drop_q, drop_d;
  logic [10:0] cnt_q, cnt_d, rd_idx_q, rd_idx_d;
  logic        ovf_q, ovf_d;
  logic [7:0]  dcnt_q, dcnt_d;
  logic        cea_q, cea_d;
  logic [10:0] ada_q, ada_d;
  logic [15:0] din_q, din_d;
  logic        p1_q, p1_d, p1_last_q, p1_last_d;
  logic        p2_q, p2_d, p2_last_q, p2_last_d;
  logic [16:0] fifo_q [3];
  logic [16:0] fifo_d [3];
  logic [1:0]  fwr_q, fwr_d, frd_q, frd_d, fcnt_q, fcnt_d;

  logic        issue, issue_last, pop, busy_w;
  logic [2:0]  credit_used;
  logic [16:0] head;

  // A read may only be issued if its word is guaranteed a FIFO slot on return.
  assign credit_used = {2'b00, p1_q} + {2'b00, p2_q} + {1'b0, fcnt_q};
  assign issue       = (st_q[r_q] == B_DRAINING) && (rd_idx_q < len_q[r_q]) && (credit_used < 3'd3);
  assign issue_last  = (rd_idx_q == (len_q[r_q] - 11'd1));
  assign head        = fifo_q[frd_q];
  assign pop         = (fcnt_q != 2'd0) && bus.out_ready;

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      st_d[i]  = st_q[i];
      len_d[i] = len_q[i];
    end
    for (int i = 0; i < 3; i++) fifo_d[i] = fifo_q[i];
    w_d       = w_q;
    r_d       = r_q;
    drop_d    = drop_q;
    cnt_d     = cnt_q;
    rd_idx_d  = rd_idx_q;
    ovf_d     = ovf_q;
    dcnt_d    = dcnt_q;
    cea_d     = 1'b0;
    ada_d     = ada_q;
    din_d     = din_q;
    fwr_d     = fwr_q;
    frd_d     = frd_q;
    fcnt_d    = fcnt_q;
    p1_d      = issue;
    p1_last_d = issue_last;
    p2_d      = p1_q;
    p2_last_d = p1_last_q;
    busy_w    = 1'b0;

    if (st_q[r_q] == B_FULL) begin
      st_d[r_q] = B_DRAINING;
      rd_idx_d  = 11'd0;
    end
    if (issue) rd_idx_d = rd_idx_q + 11'd1;

    if (p2_q) begin
      fifo_d[fwr_q] = {p2_last_q, bus.ram_dout};
      fwr_d         = (fwr_q == 2'd2) ? 2'd0 : fwr_q + 2'd1;
    end
    if (pop) begin
      frd_d = (frd_q == 2'd2) ? 2'd0 : frd_q + 2'd1;
      if (head[16]) begin
        st_d[r_q] = B_EMPTY;
        r_d       = ~r_q;
        rd_idx_d  = 11'd0;
      end
    end
    case ({p2_q, pop})
      2'b10:   fcnt_d = fcnt_q + 2'd1;
      2'b01:   fcnt_d = fcnt_q - 2'd1;
      default: fcnt_d = fcnt_q;
    endcase

    // frame_start overrides everything above; a same-cycle pixel then lands in bank 0.
    if (bus.frame_start) begin
      st_d[0]  = B_EMPTY;
      st_d[1]  = B_EMPTY;
      w_d      = 1'b0;
      r_d      = 1'b0;
      cnt_d    = 11'd0;
      drop_d   = 1'b0;
      rd_idx_d = 11'd0;
      p1_d     = 1'b0;
      p2_d     = 1'b0;
      fwr_d    = 2'd0;
      frd_d    = 2'd0;
      fcnt_d   = 2'd0;
    end

    busy_w = (st_d[w_d] == B_FULL) || (st_d[w_d] == B_DRAINING);
    if (drop_d) begin
      if (bus.line_end) drop_d = 1'b0;
    end else if (busy_w) begin
      // Retry after a drop found the bank still occupied: drop this line too.
      if (bus.pix_valid) begin
        ovf_d  = 1'b1;
        dcnt_d = (dcnt_d == 8'hFF) ? dcnt_d : dcnt_d + 8'd1;
        drop_d = ~bus.line_end;
      end
    end else begin
      st_d[w_d] = B_FILLING;
      if (bus.pix_valid && (cnt_d < LW)) begin
        cea_d = 1'b1;
        ada_d = {w_d, cnt_d[9:0]};
        din_d = bus.pix_data;
        cnt_d = cnt_d + 11'd1;
      end
      if (bus.line_end && (cnt_d != 11'd0)) begin
        st_d[w_d]  = B_FULL;
        len_d[w_d] = cnt_d;
        cnt_d      = 11'd0;
        w_d        = ~w_d;
        if (st_d[w_d] != B_EMPTY) begin
          drop_d = 1'b1;
          ovf_d  = 1'b1;
          dcnt_d = (dcnt_d == 8'hFF) ? dcnt_d : dcnt_d + 8'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 2; i++) begin
        st_q[i]  <= B_EMPTY;
        len_q[i] <= 11'd0;
      end
      for (int i = 0; i < 3; i++) fifo_q[i] <= 17'd0;
      w_q       <= 1'b0;
      r_q       <= 1'b0;
      drop_q    <= 1'b0;
      cnt_q     <= 11'd0;
      rd_idx_q  <= 11'd0;
      ovf_q     <= 1'b0;
      dcnt_q    <= 8'd0;
      cea_q     <= 1'b0;
      ada_q     <= 11'd0;
      din_q     <= 16'd0;
      p1_q      <= 1'b0;
      p1_last_q <= 1'b0;
      p2_q      <= 1'b0;
      p2_last_q <= 1'b0;
      fwr_q     <= 2'd0;
      frd_q     <= 2'd0;
      fcnt_q    <= 2'd0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        st_q[i]  <= st_d[i];
        len_q[i] <= len_d[i];
      end
      for (int i = 0; i < 3; i++) fifo_q[i] <= fifo_d[i];
      w_q       <= w_d;
      r_q       <= r_d;
      drop_q    <= drop_d;
      cnt_q     <= cnt_d;
      rd_idx_q  <= rd_idx_d;
      ovf_q     <= ovf_d;
      dcnt_q    <= dcnt_d;
      cea_q     <= cea_d;
      ada_q     <= ada_d;
      din_q     <= din_d;
      p1_q      <= p1_d;
      p1_last_q <= p1_last_d;
      p2_q      <= p2_d;
      p2_last_q <= p2_last_d;
      fwr_q     <= fwr_d;
      frd_q     <= frd_d;
      fcnt_q    <= fcnt_d;
    end
  end

  assign bus.ram_cea     = cea_q;
  assign bus.ram_ada     = ada_q;
  assign bus.ram_din     = din_q;
  assign bus.ram_ceb     = issue;
  assign bus.ram_adb     = {r_q, rd_idx_q[9:0]};
  assign bus.ram_oce     = 1'b1;
  assign bus.out_valid   = (fcnt_q != 2'd0);
  assign bus.out_data    = head[15:0];
  assign bus.out_last    = (fcnt_q != 2'd0) && head[16];
  assign bus.line_avail  = (st_q[r_q] == B_FULL);
  assign bus.overflow    = ovf_q;
  assign bus.drop_cnt    = dcnt_q;
  assign bus.dbg_bank_st = {st_q[1], st_q[0]};

endmodule

// File: tb/tb_sdpb_line_ctrl.sv
// Directed bench for sdpb_line_ctrl: RAM model, write/drain scoreboards, ready generator.
module tb_sdpb_line_ctrl;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  sdpb_line_ctrl_if bus ();

  sdpb_line_ctrl #(.LINE_WORDS(640)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int checks = 0;
  int errors = 0;
  logic [26:0] exp_wr_q[$];
  logic [16:0] exp_out_q[$];
  int acc_cnt    = 0;
  int stop_at    = 0;
  int ready_mode = 0;

  // Pipelined RAM: data appears two cycles after ram_ceb.
  logic [15:0] mem [2048];
  logic [15:0] rd1, rd2;
  always @(posedge clk) begin
    if (bus.ram_cea) mem[bus.ram_ada] <= bus.ram_din;
    if (bus.ram_ceb) rd1 <= mem[bus.ram_adb];
    if (bus.ram_oce) rd2 <= rd1;
  end
  assign bus.ram_dout = rd2;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Ready generator: 0 hold low, 1 hold high, 2 toggle, 3 high until stop_at accepts.
  initial begin
    bus.out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        1:       bus.out_ready = 1'b1;
        2:       bus.out_ready = ~bus.out_ready;
        3:       bus.out_ready = (acc_cnt < stop_at);
        default: bus.out_ready = 1'b0;
      endcase
    end
  end

  logic        stall_prev = 1'b0;
  logic        fs_prev    = 1'b0;
  logic [16:0] stall_word = 17'd0;

  always @(negedge clk) begin
    if (!reset_n) begin
      stall_prev = 1'b0;
    end else begin
      if (bus.ram_cea) begin
        if (exp_wr_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL ram_write: got write addr=0x%0h data=0x%0h expected no write", bus.ram_ada, bus.ram_din);
        end else begin
          check("ram_write", {5'd0, bus.ram_ada, bus.ram_din}, {5'd0, exp_wr_q.pop_front()});
        end
      end
      if (stall_prev && !fs_prev)
        check("stall_hold", {14'd0, bus.out_valid, bus.out_last, bus.out_data}, {14'd0, 1'b1, stall_word});
      if (bus.out_valid && bus.out_ready) begin
        acc_cnt++;
        if (exp_out_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL out_word: got data=0x%0h last=%0b expected no word", bus.out_data, bus.out_last);
        end else begin
          check("out_word", {15'd0, bus.out_last, bus.out_data}, {15'd0, exp_out_q.pop_front()});
        end
      end
      stall_prev = bus.out_valid && !bus.out_ready;
      stall_word = {bus.out_last, bus.out_data};
      fs_prev    = bus.frame_start;
    end
  end

  task automatic drive_line(input int n, input logic [15:0] base, input bit with_end);
    for (int i = 0; i < n; i++) begin
      bus.pix_valid = 1'b1;
      bus.pix_data  = base + 16'(i);
      bus.line_end  = with_end && (i == n - 1);
      @(posedge clk);
      #1;
    end
    bus.pix_valid = 1'b0;
    bus.line_end  = 1'b0;
    bus.pix_data  = 16'd0;
  endtask

  task automatic exp_writes(input bit bank, input int n, input logic [15:0] base);
    for (int i = 0; i < n; i++) exp_wr_q.push_back({bank, 10'(i), base + 16'(i)});
  endtask

  task automatic exp_reads(input int n, input logic [15:0] base);
    for (int i = 0; i < n; i++) exp_out_q.push_back({(i == n - 1), base + 16'(i)});
  endtask

  task automatic wait_idle(input int budget, input string name);
    int k;
    k = 0;
    while ((exp_wr_q.size() != 0 || exp_out_q.size() != 0) && k < budget) begin
      @(posedge clk);
      k++;
    end
    check({name, "_outstanding"}, exp_wr_q.size() + exp_out_q.size(), 0);
    exp_wr_q.delete();
    exp_out_q.delete();
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic frame_pulse();
    bus.frame_start = 1'b1;
    @(posedge clk);
    #1;
    bus.frame_start = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ram_cea"},    bus.ram_cea, 0);
    check({tag, "_ram_ceb"},    bus.ram_ceb, 0);
    check({tag, "_ram_oce"},    bus.ram_oce, 1);
    check({tag, "_ram_ada"},    bus.ram_ada, 0);
    check({tag, "_ram_adb"},    bus.ram_adb, 0);
    check({tag, "_ram_din"},    bus.ram_din, 0);
    check({tag, "_out_valid"},  bus.out_valid, 0);
    check({tag, "_out_last"},   bus.out_last, 0);
    check({tag, "_out_data"},   bus.out_data, 0);
    check({tag, "_line_avail"}, bus.line_avail, 0);
    check({tag, "_overflow"},   bus.overflow, 0);
    check({tag, "_drop_cnt"},   bus.drop_cnt, 0);
    check({tag, "_bank_st"},    bus.dbg_bank_st, 0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int acc_base;
    bus.frame_start = 1'b0;
    bus.pix_valid   = 1'b0;
    bus.pix_data    = 16'd0;
    bus.line_end    = 1'b0;
    reset_n         = 1'b1;
    #2 reset_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("rst");
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // 4-word line, line_end with the last word
    ready_mode = 1;
    exp_writes(1'b0, 4, 16'h0001);
    exp_reads(4, 16'h0001);
    drive_line(4, 16'h0001, 1'b1);
    @(negedge clk);
    check("t1_line_avail", bus.line_avail, 1);
    check("t1_bank_st", bus.dbg_bank_st, 4'b0010);
    wait_idle(200, "t1");
    check("t1_line_avail_after", bus.line_avail, 0);

    // full 640-word line into bank 1, consumer ready toggling
    ready_mode = 2;
    acc_base = acc_cnt;
    exp_writes(1'b1, 640, 16'h1000);
    exp_reads(640, 16'h1000);
    drive_line(640, 16'h1000, 1'b1);
    wait_idle(4000, "t2");
    check("t2_accepted", acc_cnt - acc_base, 640);

    // 700 words into a 640-word line: writes stop at 639
    ready_mode = 1;
    exp_writes(1'b0, 640, 16'h2000);
    exp_reads(640, 16'h2000);
    drive_line(700, 16'h2000, 1'b1);
    wait_idle(3000, "t3");
    check("t3_overflow", bus.overflow, 0);
    check("t3_drop_cnt", bus.drop_cnt, 0);

    // three 8-word lines with consumer stalled: third line dropped
    ready_mode = 0;
    frame_pulse();
    exp_writes(1'b0, 8, 16'h3000);
    exp_writes(1'b1, 8, 16'h3100);
    exp_reads(8, 16'h3000);
    exp_reads(8, 16'h3100);
    drive_line(8, 16'h3000, 1'b1);
    drive_line(8, 16'h3100, 1'b1);
    drive_line(8, 16'h3200, 1'b1);
    @(negedge clk);
    check("t4_overflow", bus.overflow, 1);
    check("t4_drop_cnt", bus.drop_cnt, 1);
    check("t4_head", {15'd0, bus.out_valid, bus.out_data}, {15'd0, 1'b1, 16'h3000});
    repeat (5) @(posedge clk);
    #1;
    ready_mode = 1;
    wait_idle(300, "t4_drain");
    exp_writes(1'b0, 8, 16'h3300);
    exp_reads(8, 16'h3300);
    drive_line(8, 16'h3300, 1'b1);
    wait_idle(300, "t4_line4");
    check("t4_drop_cnt_final", bus.drop_cnt, 1);

    // frame_start after 5 of 10 words drained from bank 1
    exp_writes(1'b1, 10, 16'h4000);
    exp_reads(10, 16'h4000);
    stop_at = acc_cnt + 5;
    ready_mode = 3;
    drive_line(10, 16'h4000, 1'b1);
    k = 0;
    while (acc_cnt < stop_at && k < 500) begin
      @(posedge clk);
      k++;
    end
    check("t5_accepted", acc_cnt - (stop_at - 5), 5);
    #1;
    exp_out_q.delete();
    frame_pulse();
    @(negedge clk);
    check("t5_out_valid_after_fs", bus.out_valid, 0);
    check("t5_line_avail_after_fs", bus.line_avail, 0);
    ready_mode = 1;
    @(posedge clk);
    #1;
    exp_writes(1'b0, 3, 16'h5000);
    exp_reads(3, 16'h5000);
    drive_line(3, 16'h5000, 1'b1);
    wait_idle(300, "t5");

    // asynchronous reset in the middle of a line in bank 1
    exp_writes(1'b1, 3, 16'h6000);
    drive_line(3, 16'h6000, 1'b0);
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    check_reset_outputs("t6");
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    exp_writes(1'b0, 2, 16'h7000);
    exp_reads(2, 16'h7000);
    drive_line(2, 16'h7000, 1'b1);
    wait_idle(200, "t6");
    check("t6_overflow", bus.overflow, 0);
    check("t6_drop_cnt", bus.drop_cnt, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
